// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending-machine controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        REFUND  = 2'b11
    } state_t;

    // Widest price table the slice helper can address.
    localparam int unsigned MAX_TABLE_W = 512;

    function automatic logic [31:0] price_slice(
        input logic [MAX_TABLE_W-1:0] table_bits,
        input int unsigned            idx,
        input int unsigned            val_w
    );
        logic [MAX_TABLE_W-1:0] shifted;
        logic [31:0]            mask;
        shifted = table_bits >> (idx * val_w);
        mask    = (val_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << val_w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/vending_out_decode.sv
// Moore output decode: controller state to dispenser/hopper strobes.
module vending_out_decode
    import vending_pkg::*;
(
    input  state_t i_state,
    output logic   o_vend_valid,
    output logic   o_money_ret,
    output logic   o_busy
);

    always_comb begin
        o_vend_valid = 1'b0;
        o_money_ret  = 1'b0;
        o_busy       = 1'b0;
        case (i_state)
            VEND: begin
                o_vend_valid = 1'b1;
                o_busy       = 1'b1;
            end
            REFUND: begin
                o_money_ret = 1'b1;
                o_busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit, item selection, vend handshake and
// unit-by-unit refund of remaining credit.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int unsigned             N_ITEMS     = 4,
    parameter int unsigned             VAL_W       = 8,
    parameter int unsigned             CHANGE_UNIT = 5,
    parameter logic [N_ITEMS*VAL_W-1:0] PRICES     = {8'd40, 8'd25, 8'd15, 8'd10}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin_valid,
    input  logic [VAL_W-1:0]           coin_value,
    output logic                       coin_accept,
    output logic                       coin_reject,
    input  logic                       sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0] sel_item,
    output logic                       sel_deny,
    input  logic                       cancel,
    output logic                       vend_valid,
    output logic [$clog2(N_ITEMS)-1:0] vend_item,
    input  logic                       vend_ready,
    output logic                       money_ret,
    output logic                       busy,
    output logic [VAL_W-1:0]           credit
);

    localparam int unsigned            IDX_W      = $clog2(N_ITEMS);
    localparam logic [VAL_W-1:0]       CU_V       = VAL_W'(CHANGE_UNIT);
    localparam logic [MAX_TABLE_W-1:0] PRICES_EXT = MAX_TABLE_W'(PRICES);

    // Every price must be a nonzero whole number of change units.
    for (genvar g = 0; g < N_ITEMS; g++) begin : g_price_chk
        if (CHANGE_UNIT == 0 ||
            price_slice(PRICES_EXT, g, VAL_W) == 0 ||
            (price_slice(PRICES_EXT, g, VAL_W) % CHANGE_UNIT) != 0) begin : g_bad
            $error("vending_ctrl: price of item %0d is not a nonzero multiple of CHANGE_UNIT", g);
        end
    end

    state_t           r_state, w_state_nxt;
    logic [VAL_W-1:0] r_credit, w_credit_nxt;
    logic [IDX_W-1:0] r_vend_item, w_vend_item_nxt;
    logic             r_coin_accept, w_coin_accept_nxt;
    logic             r_coin_reject, w_coin_reject_nxt;
    logic             r_sel_deny, w_sel_deny_nxt;

    logic [VAL_W:0]   w_sum;
    logic [VAL_W-1:0] w_price;
    logic             w_coin_ok;
    logic             w_item_ok;

    // One extra bit so an overflowing coin is caught instead of wrapping.
    assign w_sum     = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coin_ok = (coin_value != '0) && ((coin_value % CU_V) == '0) && !w_sum[VAL_W];
    assign w_price   = VAL_W'(price_slice(PRICES_EXT, 32'(sel_item), VAL_W));
    assign w_item_ok = 32'(sel_item) < 32'(N_ITEMS);

    // NOTE: every signal assigned below gets a default first, otherwise
    // paths that skip an assignment would infer latches.
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_vend_item_nxt   = r_vend_item;
        w_coin_accept_nxt = 1'b0;
        w_coin_reject_nxt = 1'b0;
        w_sel_deny_nxt    = 1'b0;

        case (r_state)
            IDLE, COLLECT: begin
                if (cancel) begin
                    w_coin_reject_nxt = coin_valid;
                    if (r_state == COLLECT) w_state_nxt = REFUND;
                end else if (sel_valid) begin
                    w_coin_reject_nxt = coin_valid;
                    if (r_state == IDLE || !w_item_ok || r_credit < w_price) begin
                        w_sel_deny_nxt = 1'b1;
                    end else begin
                        w_credit_nxt    = r_credit - w_price;
                        w_vend_item_nxt = sel_item;
                        w_state_nxt     = VEND;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_coin_accept_nxt = 1'b1;
                        w_credit_nxt      = w_sum[VAL_W-1:0];
                        w_state_nxt       = COLLECT;
                    end else begin
                        w_coin_reject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                w_coin_reject_nxt = coin_valid;
                if (vend_ready) w_state_nxt = (r_credit != '0) ? REFUND : IDLE;
            end
            REFUND: begin
                w_coin_reject_nxt = coin_valid;
                if (r_credit <= CU_V) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_credit_nxt = r_credit - CU_V;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_vend_item   <= '0;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_deny    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_vend_item   <= w_vend_item_nxt;
            r_coin_accept <= w_coin_accept_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_deny    <= w_sel_deny_nxt;
        end
    end

    vending_out_decode u_out_decode (
        .i_state      (r_state),
        .o_vend_valid (vend_valid),
        .o_money_ret  (money_ret),
        .o_busy       (busy)
    );

    assign coin_accept = r_coin_accept;
    assign coin_reject = r_coin_reject;
    assign sel_deny    = r_sel_deny;
    assign vend_item   = r_vend_item;
    assign credit      = r_credit;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_vending_ctrl;

    localparam int N  = 4;
    localparam int CU = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       coin_accept, coin_reject;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       sel_deny;
    logic       cancel;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       vend_ready;
    logic       money_ret;
    logic       busy;
    logic [7:0] credit;

    vending_ctrl #(
        .N_ITEMS     (4),
        .VAL_W       (8),
        .CHANGE_UNIT (5),
        .PRICES      ({8'd40, 8'd25, 8'd15, 8'd10})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .sel_deny    (sel_deny),
        .cancel      (cancel),
        .vend_valid  (vend_valid),
        .vend_item   (vend_item),
        .vend_ready  (vend_ready),
        .money_ret   (money_ret),
        .busy        (busy),
        .credit      (credit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Item 0 sits in the LSBs of the packed table.
    int prices[N] = '{10, 15, 25, 40};

    // Transaction-level model: credit, pending vend, refund units still owed.
    int m_credit, m_refund_left, m_item;
    bit m_pending, m_acc, m_rej, m_deny;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_acc = 0; m_rej = 0; m_deny = 0;
        if (rst) begin
            m_credit = 0; m_refund_left = 0; m_pending = 0; m_item = 0;
        end else if (m_pending) begin
            m_rej = coin_valid;
            if (vend_ready) begin
                m_pending     = 0;
                m_refund_left = m_credit / CU;
            end
        end else if (m_refund_left > 0) begin
            m_rej = coin_valid;
            m_refund_left--;
            m_credit -= CU;
        end else if (cancel) begin
            m_rej         = coin_valid;
            m_refund_left = m_credit / CU;
        end else if (sel_valid) begin
            m_rej = coin_valid;
            if (m_credit == 0 || int'(sel_item) >= N || m_credit < prices[sel_item]) begin
                m_deny = 1;
            end else begin
                m_credit -= prices[sel_item];
                m_item    = int'(sel_item);
                m_pending = 1;
            end
        end else if (coin_valid) begin
            if (coin_value != 0 && int'(coin_value) % CU == 0 && m_credit + int'(coin_value) <= 255) begin
                m_acc     = 1;
                m_credit += int'(coin_value);
            end else begin
                m_rej = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("coin_accept", 32'(coin_accept), 32'(m_acc));
            check("coin_reject", 32'(coin_reject), 32'(m_rej));
            check("sel_deny",    32'(sel_deny),    32'(m_deny));
            check("vend_valid",  32'(vend_valid),  32'(m_pending));
            check("money_ret",   32'(money_ret),   32'(m_refund_left > 0));
            check("busy",        32'(busy),        32'(m_pending || m_refund_left > 0));
            check("credit",      32'(credit),      32'(m_credit));
            check("vend_item",   32'(vend_item),   32'(m_item));
        end
    end

    task automatic cyc(input bit cv, input logic [7:0] val, input bit sv, input logic [1:0] si,
                       input bit cn, input bit vr, input bit r);
        coin_valid = cv; coin_value = val; sel_valid = sv; sel_item = si;
        cancel = cn; vend_ready = vr; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        cyc(0, 8'd0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic coin(input logic [7:0] v);
        cyc(1, v, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic sel(input logic [1:0] i);
        cyc(0, 8'd0, 1, i, 0, 0, 0);
    endtask

    task automatic drain(input int max_cyc, output int pulses);
        int n;
        n      = 0;
        pulses = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            if (money_ret === 1'b1) pulses++;
            idle_cyc();
            n++;
        end
        check("drain_timeout_busy", 32'(busy), 32'd0);
    endtask

    int pulses;
    int coins[8] = '{0, 5, 7, 10, 20, 25, 50, 100};

    initial begin
        coin_valid = 0; coin_value = 0; sel_valid = 0; sel_item = 0;
        cancel = 0; vend_ready = 0; rst = 1;
        chk_en = 1'b1;

        // Reset state.
        cyc(0, 8'd0, 0, 2'd0, 0, 0, 1);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_vend",   32'(vend_valid), 32'd0);

        // Exact-price vend, no change.
        coin(8'd10);
        check("t1_accept", 32'(coin_accept), 32'd1);
        check("t1_credit", 32'(credit), 32'd10);
        sel(2'd0);
        check("t1_vend_valid", 32'(vend_valid), 32'd1);
        check("t1_vend_item",  32'(vend_item),  32'd0);
        idle_cyc();
        check("t1_vend_held", 32'(vend_valid), 32'd1);
        cyc(0, 8'd0, 0, 2'd0, 0, 1, 0);
        check("t1_done_busy",  32'(busy),      32'd0);
        check("t1_done_money", 32'(money_ret), 32'd0);
        check("t1_done_credit", 32'(credit),   32'd0);

        // 25+25 for item 3 (40): two change units back.
        coin(8'd25);
        coin(8'd25);
        check("t2_credit50", 32'(credit), 32'd50);
        sel(2'd3);
        check("t2_credit10", 32'(credit), 32'd10);
        check("t2_vend_item", 32'(vend_item), 32'd3);
        cyc(0, 8'd0, 0, 2'd0, 0, 1, 0);
        check("t2_money_first", 32'(money_ret), 32'd1);
        drain(10, pulses);
        check("t2_pulses", 32'(pulses), 32'd2);
        check("t2_credit0", 32'(credit), 32'd0);

        // Insufficient credit then top-up for the 15-unit item.
        coin(8'd10);
        sel(2'd1);
        check("t3_deny", 32'(sel_deny), 32'd1);
        check("t3_credit", 32'(credit), 32'd10);
        coin(8'd5);
        sel(2'd1);
        check("t3_vend", 32'(vend_valid), 32'd1);
        check("t3_item", 32'(vend_item), 32'd1);
        cyc(0, 8'd0, 0, 2'd0, 0, 1, 0);
        check("t3_idle", 32'(busy), 32'd0);

        // Bad coin, overflow, coin coincident with cancel.
        coin(8'd7);
        check("t4_reject7", 32'(coin_reject), 32'd1);
        sel(2'd0);
        check("t4_idle_deny", 32'(sel_deny), 32'd1);
        coin(8'd200);
        coin(8'd50);
        check("t4_credit250", 32'(credit), 32'd250);
        coin(8'd10);
        check("t4_overflow_rej", 32'(coin_reject), 32'd1);
        check("t4_credit_kept", 32'(credit), 32'd250);
        cyc(1, 8'd10, 0, 2'd0, 1, 0, 0);
        check("t4_cancel_rej", 32'(coin_reject), 32'd1);
        drain(80, pulses);
        check("t4_pulses", 32'(pulses), 32'd50);

        // Plain cancel refund.
        coin(8'd20);
        cyc(0, 8'd0, 0, 2'd0, 1, 0, 0);
        drain(10, pulses);
        check("t5_pulses", 32'(pulses), 32'd4);

        // Inputs during a stalled vend are ignored or rejected.
        coin(8'd10);
        sel(2'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 8'd5, i[1], 2'd0, i == 4, 0, 0);
            check("t6_vend_stable", 32'(vend_valid), 32'd1);
            check("t6_no_deny", 32'(sel_deny), 32'd0);
        end
        cyc(0, 8'd0, 0, 2'd0, 0, 1, 0);
        check("t6_idle", 32'(busy), 32'd0);

        // Reset in the middle of a refund.
        coin(8'd50);
        cyc(0, 8'd0, 0, 2'd0, 1, 0, 0);
        idle_cyc();
        cyc(0, 8'd0, 0, 2'd0, 0, 0, 1);
        check("t7_credit", 32'(credit), 32'd0);
        check("t7_money", 32'(money_ret), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'(coins[$urandom_range(0, 7)]);
            cyc($urandom_range(0, 2) != 0, v,
                $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 199) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
